lcd_refresh_sched: RTL and testbench

LCD_REFRESH_SCHED -- requirements
Module: lcd_refresh_sched

---
 rtl/lcd_refresh_sched.sv | 199 +++++++++++++++++++
 tb/tb_lcd_refresh_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_sched.sv
// rtl/lcd_refresh_sched.sv - 2x16 character LCD refresh scheduler; define LCD_DIRTY_SKIP_EN to skip refreshes of an unchanged screen
module lcd_refresh_sched #(
    parameter int IDLE_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       init_done,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       send_cmd,
    output logic [3:0] cmd_nibble,
    output logic       lcd_rs,
    output logic       read_busy,
    input  logic       cmd_done,
    output logic       refresh_busy,
    output logic       frame_done
);

    localparam int CNT_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CHAR_HI,
        S_CHAR_LO,
        S_PAUSE
    } state_t;

    state_t           state_q, state_d;
    logic             line_q, line_d;
    logic [3:0]       col_q, col_d;
    logic [CNT_W-1:0] pause_cnt_q, pause_cnt_d;
    logic             pending_q, pending_d;
    logic [7:0]       char_q, char_d;
    logic [7:0]       buf_q [32];
    logic [7:0]       buf_d [32];
    logic             leave_idle;
    logic [4:0]       idx;
    logic [7:0]       hi_char;
`ifdef LCD_DIRTY_SKIP_EN
    logic             dirty_q, dirty_d;
`endif

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        col_d       = col_q;
        pause_cnt_d = pause_cnt_q;
        pending_d   = pending_q;
        char_d      = char_q;
        buf_d       = buf_q;
        send_cmd    = 1'b0;
        frame_done  = 1'b0;
        leave_idle  = 1'b0;
        idx         = {line_q, col_q};
        // Until the request is issued the latch is not loaded yet, so show the buffer value it will capture.
        hi_char     = pending_q ? char_q : buf_q[idx];

        if (wr_en) begin
            buf_d[wr_addr] = wr_data;
        end

        case (state_q)
            S_WAIT_INIT: begin
                if (init_done) begin
                    state_d    = S_ADDR_HI;
                    line_d     = 1'b0;
                    col_d      = 4'd0;
                    leave_idle = 1'b1;
                end
            end
            S_PAUSE: begin
                if (!init_done) begin
                    state_d     = S_WAIT_INIT;
                    pause_cnt_d = '0;
                end else if (pause_cnt_q == CNT_LAST) begin
`ifdef LCD_DIRTY_SKIP_EN
                    if (dirty_q) begin
                        state_d     = S_ADDR_HI;
                        line_d      = 1'b0;
                        col_d       = 4'd0;
                        pause_cnt_d = '0;
                        leave_idle  = 1'b1;
                    end
`else
                    state_d     = S_ADDR_HI;
                    line_d      = 1'b0;
                    col_d       = 4'd0;
                    pause_cnt_d = '0;
                    leave_idle  = 1'b1;
`endif
                end else begin
                    pause_cnt_d = pause_cnt_q + 1'b1;
                end
            end
            default: begin
                if (!pending_q) begin
                    if (init_done) begin
                        send_cmd  = 1'b1;
                        pending_d = 1'b1;
                        if (state_q == S_CHAR_HI) begin
                            char_d = buf_q[idx];
                        end
                    end else begin
                        state_d = S_WAIT_INIT;
                    end
                end else if (cmd_done) begin
                    pending_d = 1'b0;
                    case (state_q)
                        S_ADDR_HI: state_d = S_ADDR_LO;
                        S_ADDR_LO: state_d = S_CHAR_HI;
                        S_CHAR_HI: state_d = S_CHAR_LO;
                        default: begin
                            if (col_q == 4'd15) begin
                                col_d = 4'd0;
                                if (!line_q) begin
                                    line_d  = 1'b1;
                                    state_d = S_ADDR_HI;
                                end else begin
                                    line_d      = 1'b0;
                                    state_d     = S_PAUSE;
                                    pause_cnt_d = '0;
                                    frame_done  = 1'b1;
                                end
                            end else begin
                                col_d   = col_q + 4'd1;
                                state_d = S_CHAR_HI;
                            end
                        end
                    endcase
                    if (!init_done) begin
                        state_d = S_WAIT_INIT;
                    end
                end
            end
        endcase
    end

`ifdef LCD_DIRTY_SKIP_EN
    always_comb begin
        dirty_d = wr_en | (dirty_q & ~leave_idle);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dirty_q <= 1'b0;
        end else begin
            dirty_q <= dirty_d;
        end
    end
`endif

    always_comb begin
        cmd_nibble   = 4'd0;
        lcd_rs       = 1'b0;
        read_busy    = 1'b0;
        refresh_busy = 1'b1;
        case (state_q)
            S_ADDR_HI: cmd_nibble = line_q ? 4'hC : 4'h8;
            S_ADDR_LO: read_busy = 1'b1;
            S_CHAR_HI: begin
                cmd_nibble = hi_char[7:4];
                lcd_rs     = 1'b1;
            end
            S_CHAR_LO: begin
                cmd_nibble = char_q[3:0];
                lcd_rs     = 1'b1;
                read_busy  = 1'b1;
            end
            default: refresh_busy = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_WAIT_INIT;
            line_q      <= 1'b0;
            col_q       <= 4'd0;
            pause_cnt_q <= '0;
            pending_q   <= 1'b0;
            char_q      <= 8'h20;
            for (int i = 0; i < 32; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            col_q       <= col_d;
            pause_cnt_q <= pause_cnt_d;
            pending_q   <= pending_d;
            char_q      <= char_d;
            buf_q       <= buf_d;
        end
    end

endmodule

// File: tb/tb_lcd_refresh_sched.sv
// tb/tb_lcd_refresh_sched.sv - directed self-checking bench for lcd_refresh_sched (IDLE_CYCLES=10)
module tb_lcd_refresh_sched;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       init_done;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       send_cmd;
    logic [3:0] cmd_nibble;
    logic       lcd_rs;
    logic       read_busy;
    logic       cmd_done;
    logic       refresh_busy;
    logic       frame_done;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         fd_cnt;
    int         k;
    logic [7:0] exp_buf [32];

    lcd_refresh_sched #(.IDLE_CYCLES(10)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .init_done    (init_done),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .send_cmd     (send_cmd),
        .cmd_nibble   (cmd_nibble),
        .lcd_rs       (lcd_rs),
        .read_busy    (read_busy),
        .cmd_done     (cmd_done),
        .refresh_busy (refresh_busy),
        .frame_done   (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_send(input string tag, input logic [3:0] nib, input logic rs, input logic rb);
        int w;
        w = 0;
        while (send_cmd !== 1'b1 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        chk({tag, "_send"}, send_cmd, 1);
        chk({tag, "_nib"}, cmd_nibble, nib);
        chk({tag, "_rs"}, lcd_rs, rs);
        chk({tag, "_rb"}, read_busy, rb);
    endtask

    task automatic complete(input string tag, input logic do_wr, input logic [4:0] wa,
                            input logic [7:0] wd, input logic drop);
        logic [3:0] nib;
        nib = cmd_nibble;
        @(negedge CLK);
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        end
        if (drop) init_done = 1'b0;
        chk({tag, "_one_shot"}, send_cmd, 0);
        @(negedge CLK);
        wr_en = 1'b0;
        chk({tag, "_stable"}, cmd_nibble, nib);
        @(negedge CLK);
        cmd_done = 1'b1;
        #1;
        if (frame_done === 1'b1) fd_cnt++;
        @(negedge CLK);
        cmd_done = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int wr_nib, input logic [4:0] wa, input logic [7:0] wd);
        int         kk, c;
        logic       ln, hi;
        logic [7:0] ch;
        logic [3:0] nib;
        fd_cnt = 0;
        for (int n = 0; n < 68; n++) begin
            ln = (n >= 34);
            kk = n % 34;
            if (kk == 0) begin
                expect_send(tag, ln ? 4'hC : 4'h8, 1'b0, 1'b0);
            end else if (kk == 1) begin
                expect_send(tag, 4'h0, 1'b0, 1'b1);
            end else begin
                c   = (kk - 2) / 2;
                hi  = (kk % 2 == 0);
                ch  = exp_buf[ln * 16 + c];
                nib = hi ? ch[7:4] : ch[3:0];
                expect_send(tag, nib, 1'b1, !hi);
            end
            if (n == 66) chk({tag, "_fd_early"}, fd_cnt, 0);
            complete(tag, n == wr_nib, wa, wd, 1'b0);
        end
        chk({tag, "_frame_done_once"}, fd_cnt, 1);
        chk({tag, "_pause_idle"}, refresh_busy, 0);
    endtask

    initial begin
        RESET_N = 1'b0; init_done = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; cmd_done = 1'b0;
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        repeat (2) @(negedge CLK);
        chk("rst_send", send_cmd, 0);
        chk("rst_nib", cmd_nibble, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rb", read_busy, 0);
        chk("rst_busy", refresh_busy, 0);
        chk("rst_fd", frame_done, 0);
        RESET_N = 1'b1;

        // Write before init: must be shown once refresh begins.
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 8'h41;
        exp_buf[17] = 8'h41;
        @(negedge CLK);
        wr_en = 1'b0;
        repeat (4) @(negedge CLK);
        chk("wait_init_send", send_cmd, 0);
        chk("wait_init_busy", refresh_busy, 0);

        init_done = 1'b1;
        run_frame("f1", -1, 5'd0, 8'd0);

`ifdef LCD_DIRTY_SKIP_EN
        k = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (send_cmd === 1'b1) k++;
        end
        chk("dirty_no_refresh", k, 0);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h20;
        @(negedge CLK);
        wr_en = 1'b0;
`else
        k = 0;
        while (send_cmd !== 1'b1 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("pause_len", k, 10);
`endif

        // Write to addr 3 while CHAR_HI col 3 is outstanding (nibble 8): latched old value stays.
        run_frame("f2", 8, 5'd3, 8'h5A);
        exp_buf[3] = 8'h5A;
        run_frame("f3", -1, 5'd0, 8'd0);

        // Drop init_done during a character nibble.
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 8'h20;
        @(negedge CLK);
        wr_en = 1'b0;
        expect_send("drop_a", 4'h8, 1'b0, 1'b0);
        complete("drop_a", 1'b0, 5'd0, 8'd0, 1'b0);
        expect_send("drop_b", 4'h0, 1'b0, 1'b1);
        complete("drop_b", 1'b0, 5'd0, 8'd0, 1'b0);
        expect_send("drop_c", 4'h2, 1'b1, 1'b0);
        complete("drop_c", 1'b0, 5'd0, 8'd0, 1'b1);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            if (send_cmd === 1'b1) k++;
            @(negedge CLK);
        end
        chk("drop_no_send", k, 0);
        chk("drop_idle", refresh_busy, 0);

        // Reset during an outstanding nibble.
        init_done = 1'b1;
        expect_send("rst_mid", 4'h8, 1'b0, 1'b0);
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_send", send_cmd, 0);
        chk("async_nib", cmd_nibble, 0);
        chk("async_rs", lcd_rs, 0);
        chk("async_rb", read_busy, 0);
        chk("async_busy", refresh_busy, 0);
        chk("async_fd", frame_done, 0);
        init_done = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        cmd_done = 1'b1;
        @(negedge CLK);
        cmd_done = 1'b0;
        @(negedge CLK);
        chk("stray_done_send", send_cmd, 0);
        chk("stray_done_busy", refresh_busy, 0);

        // Buffer returned to spaces: plain all-blank frame.
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        init_done = 1'b1;
        run_frame("f4", -1, 5'd0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
